// File: rtl/wave_controller.sv
// -----------------------------------------------------------------------------
// wave_controller
//
// Game-level sequencer for the invaders formation. Holds the formation in
// reset outside of play, gates player firing, watches the formation occupancy,
// row and hit/death pulses, and keeps score, lives, level and the formation
// tick period for the current level.
//
// Ports
//   i_clk_36MHz       system clock
//   i_reset           synchronous, active-high reset
//   i_start           start button (rising edge used)
//   i_hit             formation hit flag (rising edge = one kill)
//   i_player_dead     player destroyed (rising edge used)
//   i_invaders_array  formation occupancy, 0 = wave cleared
//   i_invaders_row    formation row, >= INVADE_ROW ends the game
//   o_invaders_reset  reset to the formation block
//   o_fire_enable     player may fire
//   o_state           IDLE=0, LOAD=1, PLAY=2, WAVE_CLEAR=3, GAME_OVER=4
//   o_score           binary score, saturating at SCORE_MAX
//   o_lives           remaining lives
//   o_level           current wave, saturating at 7
//   o_speed           formation tick period for the current level (us)
//   o_game_over       high while in GAME_OVER
// -----------------------------------------------------------------------------
module wave_controller #(
  parameter int LIVES        = 3,
  parameter int POINTS       = 10,
  parameter int SCORE_MAX    = 9999,
  parameter int LOAD_CYCLES  = 4,
  parameter int PAUSE_CYCLES = 1000000,
  parameter int INVADE_ROW   = 14,
  parameter int BASE_SPEED   = 100000,
  parameter int SPEED_STEP   = 12000,
  parameter int MIN_SPEED    = 16000
) (
  input  logic        i_clk_36MHz,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_hit,
  input  logic        i_player_dead,
  input  logic [19:0] i_invaders_array,
  input  logic [3:0]  i_invaders_row,
  output logic        o_invaders_reset,
  output logic        o_fire_enable,
  output logic [2:0]  o_state,
  output logic [13:0] o_score,
  output logic [1:0]  o_lives,
  output logic [2:0]  o_level,
  output logic [19:0] o_speed,
  output logic        o_game_over
);

  // Counter widths: each counter only has to reach CYCLES-1.
  localparam int LOAD_W  = (LOAD_CYCLES  > 1) ? $clog2(LOAD_CYCLES)  : 1;
  localparam int PAUSE_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;

  localparam logic [LOAD_W-1:0]  LOAD_LAST    = LOAD_W'(LOAD_CYCLES - 1);
  localparam logic [PAUSE_W-1:0] PAUSE_LAST   = PAUSE_W'(PAUSE_CYCLES - 1);
  localparam logic [13:0]        SCORE_MAX_V  = 14'(SCORE_MAX);
  localparam logic [14:0]        POINTS_V     = 15'(POINTS);
  localparam logic [1:0]         LIVES_V      = 2'(LIVES);
  localparam logic [3:0]         INVADE_ROW_V = 4'(INVADE_ROW);
  localparam logic [19:0]        BASE_SPEED_V = 20'(BASE_SPEED);
  localparam logic [19:0]        MIN_SPEED_V  = 20'(MIN_SPEED);
  localparam logic signed [23:0] BASE_S       = 24'(BASE_SPEED);
  localparam logic signed [23:0] STEP_S       = 24'(SPEED_STEP);
  localparam logic signed [23:0] MIN_S        = 24'(MIN_SPEED);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_PLAY       = 3'd2,
    ST_WAVE_CLEAR = 3'd3,
    ST_GAME_OVER  = 3'd4
  } state_e;

  state_e               state_q;
  logic                 start_prev_q;
  logic                 hit_prev_q;
  logic                 dead_prev_q;
  logic [LOAD_W-1:0]    load_cnt_q;
  logic [PAUSE_W-1:0]   pause_cnt_q;
  logic [13:0]          score_q;
  logic [1:0]           lives_q;
  logic [2:0]           level_q;
  logic [19:0]          speed_q;
  logic                 inv_reset_q;
  logic                 fire_q;
  logic                 game_over_q;

  logic                 start_rise_s;
  logic                 hit_rise_s;
  logic                 dead_rise_s;
  logic [14:0]          score_sum_s;
  logic [13:0]          score_d;
  logic [1:0]           lives_d;
  logic [2:0]           level_d;
  logic signed [23:0]   level_ext_s;
  logic signed [23:0]   speed_raw_s;
  logic [19:0]          speed_d;

  assign start_rise_s = i_start       & ~start_prev_q;
  assign hit_rise_s   = i_hit         & ~hit_prev_q;
  assign dead_rise_s  = i_player_dead & ~dead_prev_q;

  // Saturating score increment; one extra bit catches the overshoot.
  always_comb begin
    score_sum_s = {1'b0, score_q} + POINTS_V;
    if (score_sum_s > {1'b0, SCORE_MAX_V}) begin
      score_d = SCORE_MAX_V;
    end else begin
      score_d = score_sum_s[13:0];
    end
  end

  // Lives decrement and saturating level increment.
  always_comb begin
    lives_d = lives_q - 2'd1;
    if (level_q == 3'd7) begin
      level_d = 3'd7;
    end else begin
      level_d = level_q + 3'd1;
    end
  end

  // Tick period for the current level, clamped at the floor. Signed so a
  // large level*step cannot wrap into a huge unsigned period.
  always_comb begin
    level_ext_s = {21'd0, level_q};
    speed_raw_s = BASE_S - (level_ext_s * STEP_S);
    if (speed_raw_s < MIN_S) begin
      speed_d = MIN_SPEED_V;
    end else begin
      speed_d = speed_raw_s[19:0];
    end
  end

  // Game sequencer: state, counters, score/lives/level/speed and the
  // registered formation-reset, fire-enable and game-over outputs.
  always_ff @(posedge i_clk_36MHz) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b1;   // a start held through reset must be re-pressed
      hit_prev_q   <= 1'b0;
      dead_prev_q  <= 1'b0;
      load_cnt_q   <= '0;
      pause_cnt_q  <= '0;
      score_q      <= 14'd0;
      lives_q      <= LIVES_V;
      level_q      <= 3'd0;
      speed_q      <= BASE_SPEED_V;
      inv_reset_q  <= 1'b1;
      fire_q       <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      start_prev_q <= i_start;
      hit_prev_q   <= i_hit;
      dead_prev_q  <= i_player_dead;
      // Follows level_q one cycle later; GAME_OVER restart overrides below.
      speed_q      <= speed_d;

      case (state_q)
        ST_IDLE: begin
          inv_reset_q <= 1'b1;
          fire_q      <= 1'b0;
          game_over_q <= 1'b0;
          if (start_rise_s) begin
            state_q    <= ST_LOAD;
            load_cnt_q <= '0;
          end
        end

        ST_LOAD: begin
          if (load_cnt_q == LOAD_LAST) begin
            state_q     <= ST_PLAY;
            load_cnt_q  <= '0;
            inv_reset_q <= 1'b0;
            fire_q      <= 1'b1;
          end else begin
            load_cnt_q  <= load_cnt_q + {{(LOAD_W-1){1'b0}}, 1'b1};
          end
        end

        ST_PLAY: begin
          // A kill scores even on the cycle that leaves PLAY.
          if (hit_rise_s) begin
            score_q <= score_d;
          end
          if (i_invaders_row >= INVADE_ROW_V) begin
            state_q     <= ST_GAME_OVER;
            inv_reset_q <= 1'b1;
            fire_q      <= 1'b0;
            game_over_q <= 1'b1;
          end else if (dead_rise_s) begin
            lives_q     <= lives_d;
            inv_reset_q <= 1'b1;
            fire_q      <= 1'b0;
            if (lives_d == 2'd0) begin
              state_q     <= ST_GAME_OVER;
              game_over_q <= 1'b1;
            end else begin
              state_q    <= ST_LOAD;
              load_cnt_q <= '0;
            end
          end else if (i_invaders_array == 20'd0) begin
            state_q     <= ST_WAVE_CLEAR;
            pause_cnt_q <= '0;
            level_q     <= level_d;
            inv_reset_q <= 1'b1;
            fire_q      <= 1'b0;
          end
        end

        ST_WAVE_CLEAR: begin
          if (pause_cnt_q == PAUSE_LAST) begin
            state_q     <= ST_LOAD;
            pause_cnt_q <= '0;
            load_cnt_q  <= '0;
          end else begin
            pause_cnt_q <= pause_cnt_q + {{(PAUSE_W-1){1'b0}}, 1'b1};
          end
        end

        ST_GAME_OVER: begin
          if (start_rise_s) begin
            state_q     <= ST_LOAD;
            load_cnt_q  <= '0;
            score_q     <= 14'd0;
            lives_q     <= LIVES_V;
            level_q     <= 3'd0;
            speed_q     <= BASE_SPEED_V;
            game_over_q <= 1'b0;
          end
        end

        default: begin
          // Unreachable encodings recover to IDLE.
          state_q     <= ST_IDLE;
          load_cnt_q  <= '0;
          pause_cnt_q <= '0;
          inv_reset_q <= 1'b1;
          fire_q      <= 1'b0;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_state          = state_q;
  assign o_invaders_reset = inv_reset_q;
  assign o_fire_enable    = fire_q;
  assign o_score          = score_q;
  assign o_lives          = lives_q;
  assign o_level          = level_q;
  assign o_speed          = speed_q;
  assign o_game_over      = game_over_q;

endmodule

// File: tb/tb_wave_controller.sv
// -----------------------------------------------------------------------------
// tb_wave_controller
//
// Directed scenarios plus randomized stimulus for wave_controller, checked
// every cycle against a behavioural game model held in plain integers.
// -----------------------------------------------------------------------------
module tb_wave_controller;

  localparam int LIVES   = 3;
  localparam int LOAD_C  = 4;
  localparam int PAUSE_C = 8;
  localparam int BASE    = 100000;
  localparam int STEP    = 12000;
  localparam int MINSP   = 16000;

  logic        clk;
  logic        rst;
  logic        start;
  logic        hit;
  logic        dead;
  logic [19:0] arr;
  logic [3:0]  row;
  logic        inv_reset;
  logic        fire_en;
  logic [2:0]  state;
  logic [13:0] score;
  logic [1:0]  lives;
  logic [2:0]  level;
  logic [19:0] speed;
  logic        game_over;

  wave_controller #(
    .LIVES(LIVES), .POINTS(10), .SCORE_MAX(9999), .LOAD_CYCLES(LOAD_C),
    .PAUSE_CYCLES(PAUSE_C), .INVADE_ROW(14), .BASE_SPEED(BASE),
    .SPEED_STEP(STEP), .MIN_SPEED(MINSP)
  ) dut (
    .i_clk_36MHz(clk), .i_reset(rst), .i_start(start), .i_hit(hit),
    .i_player_dead(dead), .i_invaders_array(arr), .i_invaders_row(row),
    .o_invaders_reset(inv_reset), .o_fire_enable(fire_en), .o_state(state),
    .o_score(score), .o_lives(lives), .o_level(level), .o_speed(speed),
    .o_game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural game model: state names as numbers, counters count down.
  int m_state = 0;
  int m_score = 0;
  int m_lives = LIVES;
  int m_level = 0;
  int m_speed = BASE;
  int m_left  = 0;
  bit m_sp = 1'b1;
  bit m_hp = 1'b0;
  bit m_dp = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int period_for(input int lvl);
    int p;
    p = BASE - lvl * STEP;
    return (p < MINSP) ? MINSP : p;
  endfunction

  task automatic model_step();
    bit sr, hr, dr;
    if (rst) begin
      m_state = 0; m_score = 0; m_lives = LIVES; m_level = 0;
      m_speed = BASE; m_left = 0; m_sp = 1'b1; m_hp = 1'b0; m_dp = 1'b0;
      return;
    end
    sr = start & !m_sp;
    hr = hit & !m_hp;
    dr = dead & !m_dp;
    m_sp = start; m_hp = hit; m_dp = dead;
    m_speed = period_for(m_level);   // lags the level by one cycle
    case (m_state)
      0: if (sr) begin m_state = 1; m_left = LOAD_C; end
      1: begin
        m_left--;
        if (m_left == 0) m_state = 2;
      end
      2: begin
        if (hr) m_score = (m_score + 10 > 9999) ? 9999 : m_score + 10;
        if (row >= 14) m_state = 4;
        else if (dr) begin
          m_lives--;
          if (m_lives == 0) m_state = 4;
          else begin m_state = 1; m_left = LOAD_C; end
        end else if (arr == 0) begin
          m_state = 3; m_left = PAUSE_C;
          m_level = (m_level >= 7) ? 7 : m_level + 1;
        end
      end
      3: begin
        m_left--;
        if (m_left == 0) begin m_state = 1; m_left = LOAD_C; end
      end
      4: if (sr) begin
        m_score = 0; m_lives = LIVES; m_level = 0; m_speed = BASE;
        m_state = 1; m_left = LOAD_C;
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic compare_all();
    check_eq("state", state, m_state);
    check_eq("score", score, m_score);
    check_eq("lives", lives, m_lives);
    check_eq("level", level, m_level);
    check_eq("speed", speed, m_speed);
    check_eq("inv_reset", inv_reset, (m_state != 2) ? 1 : 0);
    check_eq("fire_en", fire_en, (m_state == 2) ? 1 : 0);
    check_eq("game_over", game_over, (m_state == 4) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic wait_state(input int s, input int budget, input string tag);
    int n;
    n = 0;
    while (m_state != s && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, state, s);
  endtask

  task automatic press_start();
    start = 1'b1; tick();
    start = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hit = 1'b0; dead = 1'b0;
    arr = 20'hFFFFF; row = 4'd0;

    // 1: reset, start, LOAD for four cycles, then PLAY
    tick(); tick();
    check_eq("reset_speed", speed, 100000);
    check_eq("reset_inv", inv_reset, 1);
    rst = 1'b0; tick();
    start = 1'b1; tick();
    check_eq("enter_load", state, 1);
    start = 1'b0;
    tick(); tick(); tick();
    check_eq("still_load", state, 1);
    tick();
    check_eq("enter_play", state, 2);
    check_eq("play_fire", fire_en, 1);

    // 2: held hit counts once, then a pulse; then saturate the score
    hit = 1'b1; tick(); tick(); tick();
    hit = 1'b0; tick();
    hit = 1'b1; tick();
    hit = 1'b0; tick();
    check_eq("score_20", score, 20);
    for (int i = 0; i < 1000; i++) begin
      hit = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      hit = 1'b0;
      repeat ($urandom_range(1, 2)) tick();
    end
    check_eq("score_sat", score, 9999);

    // 3: nine wave clears, level saturating at 7 and speed at the floor
    for (int w = 0; w < 9; w++) begin
      arr = 20'd0; tick();
      check_eq("enter_clear", state, 3);
      arr = 20'($urandom_range(1, 20'hFFFFF));
      if (w == 0) begin
        tick();
        check_eq("lvl1_speed", speed, 88000);
      end
      wait_state(2, 40, "clear_to_play");
    end
    check_eq("level_sat", level, 7);
    check_eq("speed_floor", speed, 16000);

    // 4: three deaths, keep the score
    for (int d = 0; d < 3; d++) begin
      dead = 1'b1; tick();
      dead = 1'b0; tick();
      if (d < 2) wait_state(2, 20, "death_reload");
    end
    check_eq("dead_over", state, 4);
    check_eq("dead_lives", lives, 0);
    check_eq("dead_score", score, 9999);

    // 5: restart, then invasion beats a simultaneous death and clear
    press_start();
    wait_state(2, 20, "restart_play");
    row = 4'd14; dead = 1'b1; arr = 20'd0; tick();
    check_eq("invade_over", state, 4);
    check_eq("invade_lives", lives, 3);
    row = 4'd0; dead = 1'b0; arr = 20'h0F0F0; tick();
    start = 1'b1; tick();
    check_eq("restart_load", state, 1);
    check_eq("restart_score", score, 0);
    check_eq("restart_level", level, 0);
    start = 1'b0;

    // 6: reset mid-WAVE_CLEAR with start held
    wait_state(2, 20, "r6_play");
    arr = 20'd0; tick();
    arr = 20'h00001; tick(); tick();
    check_eq("r6_clear", state, 3);
    start = 1'b1; rst = 1'b1; tick();
    check_eq("r6_idle", state, 0);
    rst = 1'b0; tick(); tick(); tick();
    check_eq("r6_held", state, 0);
    start = 1'b0; tick();
    start = 1'b1; tick();
    check_eq("r6_load", state, 1);
    start = 1'b0;

    // Random play
    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 7) == 0);
      hit   = ($urandom_range(0, 2) == 0);
      dead  = ($urandom_range(0, 39) == 0);
      arr   = ($urandom_range(0, 19) == 0) ? 20'd0 : 20'($urandom_range(1, 20'hFFFFF));
      row   = ($urandom_range(0, 59) == 0) ? 4'($urandom_range(14, 15)) : 4'($urandom_range(0, 13));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wave_controller.md
Name: wave_controller

Overview:
Game-level sequencer for the invaders formation block.
- Owns the formation's synchronous reset and gates player firing.
- Watches formation array/row and hit pulses to detect wave cleared, invasion and player death.
- Keeps score, lives and level, and publishes the formation tick period for the current level.

Parameters:
LIVES, 3, lives at game start (1..3)
POINTS, 10, score added per invader hit
SCORE_MAX, 9999, score saturation value
LOAD_CYCLES, 4, cycles o_invaders_reset is held in LOAD (>=1)
PAUSE_CYCLES, 1000000, cycles spent in WAVE_CLEAR (>=1)
INVADE_ROW, 14, formation row that ends the game
BASE_SPEED, 100000, level-0 tick period in us
SPEED_STEP, 12000, period decrease per level
MIN_SPEED, 16000, period floor

Ports:
i_clk_36MHz  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_start  in  1  start button, level; rising edge used
i_hit  in  1  formation hit flag; rising edge = one kill
i_player_dead  in  1  player destroyed; rising edge used
i_invaders_array  in  20  formation occupancy
i_invaders_row  in  4  formation row
o_invaders_reset  out  1  reset to formation block
o_fire_enable  out  1  player may fire
o_state  out  3  IDLE=0, LOAD=1, PLAY=2, WAVE_CLEAR=3, GAME_OVER=4
o_score  out  14  binary score
o_lives  out  2  remaining lives
o_level  out  3  current wave, saturates at 7
o_speed  out  20  tick period for current level
o_game_over  out  1  high in GAME_OVER

Behaviour:
- Reset values:
  - state IDLE; o_invaders_reset=1; o_fire_enable=0.
  - o_score=0; o_lives=LIVES; o_level=0; o_speed=BASE_SPEED; o_game_over=0.
  - Edge registers: start_prev=1, hit_prev=0, dead_prev=0.
  - Load and pause counters = 0.
- Reset priority: i_reset in any state restores all reset values next cycle.
- Edge detection: x_rise = x & ~x_prev. All prev registers update every cycle. A button held through reset must be released and re-pressed.
- All outputs are registered. o_invaders_reset and o_fire_enable follow the state entered, in the same cycle the state register changes.
- IDLE: formation held in reset, no firing. start_rise -> LOAD.
- LOAD:
  - o_invaders_reset=1, o_fire_enable=0.
  - Counter runs 0..LOAD_CYCLES-1; on the last count -> PLAY, counter cleared.
- PLAY:
  - o_invaders_reset=0, o_fire_enable=1.
  - hit_rise: score += POINTS, saturating at SCORE_MAX. Applied even on a cycle that also leaves PLAY.
  - Exit priority, one per cycle:
    1. i_invaders_row >= INVADE_ROW -> GAME_OVER.
    2. dead_rise: lives-1. If the result is 0 -> GAME_OVER, else -> LOAD. Score and level unchanged.
    3. i_invaders_array == 0 -> WAVE_CLEAR. On entry, level += 1 (saturate at 7) and o_speed is recomputed.
- WAVE_CLEAR:
  - o_invaders_reset=1, o_fire_enable=0.
  - Counter runs PAUSE_CYCLES cycles, then -> LOAD.
  - Hits and deaths are ignored.
- GAME_OVER:
  - o_game_over=1, o_invaders_reset=1, o_fire_enable=0.
  - start_rise: score=0, lives=LIVES, level=0, speed=BASE_SPEED, o_game_over=0 -> LOAD.
- Outside PLAY, hit_rise and dead_rise are ignored.
- o_speed rule: max(BASE_SPEED - level*SPEED_STEP, MIN_SPEED). Compute in 24-bit signed, registered, updated the cycle after level changes.
- Unused state codes 5..7 -> IDLE next cycle.

Test Plan:
1. Reset, then i_start pulse -> LOAD for 4 cycles, then PLAY; o_invaders_reset 1->0, o_fire_enable 0->1, o_speed=100000.
2. PLAY, i_hit held high 3 cycles, then low, then another 1-cycle pulse -> o_score=20. Preload 9995, one hit -> o_score=9999.
3. PLAY, array forced to 0 (PAUSE_CYCLES=8 in bench) -> WAVE_CLEAR 8 cycles, o_level=1, o_speed=88000, then LOAD, then PLAY. Seven more clears -> o_level=7, o_speed=16000.
4. PLAY, three i_player_dead pulses -> lives 2 (LOAD), 1 (LOAD), then GAME_OVER with o_game_over=1; score retained.
5. PLAY, row=14 and dead_rise and array=0 in the same cycle -> GAME_OVER, lives unchanged. Then i_start -> score 0, lives 3, level 0, LOAD.
6. i_reset asserted mid-WAVE_CLEAR with i_start held high -> IDLE next cycle with all reset values. No start until i_start falls and rises again.
